alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter BITS, default 8, operand/result width.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 i_req_valid_0 / i_req_valid_1  input  1 each  requester k has an operation pending.
REQ-005 o_req_ready_0 / o_req_ready_1  output  1 each  requester k's operation is accepted this cycle.
REQ-006 i_a_0, i_b_0, i_a_1, i_b_1  input  BITS each  operands of requester k.
REQ-007 i_op_0, i_op_1  input  2 each  opcode: 00 subtract, 01 compare, 10 shift, 11 bit-change.
REQ-008 o_rsp_valid  output  1  result registers hold an undelivered result.
REQ-009 i_rsp_ready  input  1  consumer accepts the result.
REQ-010 o_rsp_id  output  1  index of the requester that issued the result.
REQ-011 o_out  output  BITS; o_ovf, o_err, o_even, o_single  output  1 each  registered ALU outputs.
REQ-012 o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The block SHALL share one ALU instance between two requesters, one operation in flight at a time.
REQ-014 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-015 In IDLE, grant: if one valid, grant it; if both valid, grant the requester named by the round-robin pointer.
REQ-016 o_req_ready_k SHALL be combinational and high only in IDLE for the granted k; it stays low in EXEC and RESP, and is never high for both requesters.
REQ-017 On valid&ready, the block SHALL latch a, b, op and id, set the pointer to the other requester, and go to EXEC.
REQ-018 In EXEC, the latched operands drive the ALU; at the next edge all five ALU outputs and the id are captured, o_rsp_valid rises, and the state becomes RESP.
REQ-019 Latency: o_rsp_valid SHALL be high exactly 2 edges after the accepting edge.
REQ-020 In RESP, o_rsp_valid, o_rsp_id, o_out and the flags SHALL stay stable until i_rsp_ready is high.
REQ-021 On o_rsp_valid&i_rsp_ready, the block SHALL drop o_rsp_valid and go to IDLE; a new grant is possible in the cycle after.
REQ-022 Sustained throughput SHALL be one operation per 3 cycles.
REQ-023 Results SHALL be bit-identical to the ALU driven directly with the same a, b, op.
REQ-024 The pointer SHALL change only on an accepted request; while the pointer-side requester is idle, the other is served repeatedly.
REQ-025 Request inputs outside IDLE SHALL be ignored; request inputs SHALL NOT be sampled before their handshake.

Reset
REQ-026 While i_rst is high: state IDLE, pointer 0, o_rsp_valid 0, o_rsp_id 0, o_out 0, all flags 0, o_busy 0, both o_req_ready 0.
REQ-027 If reset asserts in EXEC or RESP, the in-flight operation SHALL be discarded and never presented.
REQ-028 The first edge after i_rst falls SHALL evaluate IDLE grants normally.

Structure
REQ-029 Package alu_pkg SHALL hold the opcode enum (OP_SUB, OP_CMP, OP_SHIFT, OP_BIT) and the FSM state enum (IDLE, EXEC, RESP).
REQ-030 The existing ALU module SHALL be the only sub-module, instantiated once with BITS passed through.

Verification
REQ-031 Single request, req0 a=0xD2 b=0xD5 op=00 -> ready_0 is high 1 cycle; 2 edges later o_rsp_valid=1, id=0, o_out=0xFD.
REQ-032 Both valid after reset, req0 0x07-0x40, req1 0x6F-0x18 -> req0 served first (o_out 0xC7, id 0), then req1 (o_out 0x57, id 1); ready never high on both.
REQ-033 Backpressure: i_rsp_ready held 0 for 5 cycles in RESP -> outputs constant, ready_0/1 low, o_busy 1; accepted on cycle 6.
REQ-034 Reset pulse during EXEC -> all outputs 0 next sample, no o_rsp_valid for that op, pointer 0.
REQ-035 Random ops on both ports, i_rsp_ready random, 1000 ops -> each result equals a standalone ALU reference; per-requester order preserved; no requester waits more than one other grant while both are valid.
REQ-036 Only req1 valid for 3 consecutive ops -> served each time (pointer does not block).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter: opcodes, FSM states, result flags
// and the round-robin grant helper.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_SUB   = 2'b00,
    OP_CMP   = 2'b01,
    OP_SHIFT = 2'b10,
    OP_BIT   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic ovf;
    logic err;
    logic even;
    logic single;
  } flags_t;

  // One-hot grant: a lone requester always wins, a tie goes to the pointer side.
  function automatic logic [1:0] rr_pick(input logic [1:0] vld, input logic ptr);
    logic [1:0] gnt;
    if (vld == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else begin
      gnt = vld;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: subtract, compare, shift and single-bit toggle with flags.
// Zero latency; no handshake of its own.
module alu
  import alu_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  input  op_e             i_op,
  output logic [BITS-1:0] o_out,
  output logic            o_ovf,
  output logic            o_err,
  output logic            o_even,
  output logic            o_single
);

  localparam int SW = $clog2(BITS);

  logic [SW-1:0]     amt;
  logic [BITS-1:0]   diff;
  logic [2*BITS-1:0] shl_w;
  logic [BITS-1:0]   res;
  logic              ovf;
  logic              err;

  always_comb begin
    amt   = i_b[SW-1:0];
    diff  = i_a - i_b;
    shl_w = {{BITS{1'b0}}, i_a} << amt;
    res   = '0;
    ovf   = 1'b0;
    err   = 1'b0;
    unique case (i_op)
      OP_SUB: begin
        res = diff;
        ovf = (i_a[BITS-1] ^ i_b[BITS-1]) & (diff[BITS-1] ^ i_a[BITS-1]);
      end
      OP_CMP: begin
        res[0] = i_a < i_b;
        res[1] = i_a == i_b;
        res[2] = $signed(i_a) < $signed(i_b);
      end
      // b[MSB] selects right shift; bits between the amount and the MSB must be zero.
      OP_SHIFT: begin
        err = |i_b[BITS-2:SW];
        if (i_b[BITS-1]) begin
          res = i_a >> amt;
        end else begin
          res = shl_w[BITS-1:0];
          ovf = |shl_w[2*BITS-1:BITS];
        end
      end
      OP_BIT: begin
        err = |i_b[BITS-1:SW];
        res = err ? i_a : (i_a ^ (BITS'(1) << amt));
      end
    endcase
    o_out    = res;
    o_ovf    = ovf;
    o_err    = err;
    o_even   = ~^res;
    o_single = $onehot(res);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU, one op in flight; result valid 2 edges after accept.
// Result held stable while i_rsp_ready is low; requests are not accepted until it drains.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid_0,
  input  logic            i_req_valid_1,
  output logic            o_req_ready_0,
  output logic            o_req_ready_1,
  input  logic [BITS-1:0] i_a_0,
  input  logic [BITS-1:0] i_b_0,
  input  logic [BITS-1:0] i_a_1,
  input  logic [BITS-1:0] i_b_1,
  input  logic [1:0]      i_op_0,
  input  logic [1:0]      i_op_1,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic            o_rsp_id,
  output logic [BITS-1:0] o_out,
  output logic            o_ovf,
  output logic            o_err,
  output logic            o_even,
  output logic            o_single,
  output logic            o_busy
);

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  op_e             op_q, op_d;
  logic            id_q, id_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic            rsp_id_q, rsp_id_d;
  logic [BITS-1:0] out_q, out_d;
  flags_t          flg_q, flg_d;

  logic [1:0]      gnt;
  logic            accept_en;
  logic [BITS-1:0] alu_out;
  logic            alu_ovf;
  logic            alu_err;
  logic            alu_even;
  logic            alu_single;

  alu #(
    .BITS(BITS)
  ) u_alu (
    .i_a     (a_q),
    .i_b     (b_q),
    .i_op    (op_q),
    .o_out   (alu_out),
    .o_ovf   (alu_ovf),
    .o_err   (alu_err),
    .o_even  (alu_even),
    .o_single(alu_single)
  );

  // Ready is masked during reset so nothing can appear accepted while state is forced.
  assign gnt           = rr_pick({i_req_valid_1, i_req_valid_0}, ptr_q);
  assign accept_en     = (state_q == IDLE) && !i_rst;
  assign o_req_ready_0 = accept_en & gnt[0];
  assign o_req_ready_1 = accept_en & gnt[1];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    id_d      = id_q;
    rsp_vld_d = rsp_vld_q;
    rsp_id_d  = rsp_id_q;
    out_d     = out_q;
    flg_d     = flg_q;
    unique case (state_q)
      IDLE: begin
        if (o_req_ready_0 || o_req_ready_1) begin
          id_d    = o_req_ready_1;
          a_d     = o_req_ready_1 ? i_a_1 : i_a_0;
          b_d     = o_req_ready_1 ? i_b_1 : i_b_0;
          op_d    = op_e'(o_req_ready_1 ? i_op_1 : i_op_0);
          ptr_d   = ~o_req_ready_1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        out_d        = alu_out;
        flg_d.ovf    = alu_ovf;
        flg_d.err    = alu_err;
        flg_d.even   = alu_even;
        flg_d.single = alu_single;
        rsp_id_d     = id_q;
        rsp_vld_d    = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_SUB;
      id_q      <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
      out_q     <= '0;
      flg_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      id_q      <= id_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      out_q     <= out_d;
      flg_q     <= flg_d;
    end
  end

  assign o_rsp_valid = rsp_vld_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_out       = out_q;
  assign o_ovf       = flg_q.ovf;
  assign o_err       = flg_q.err;
  assign o_even      = flg_q.even;
  assign o_single    = flg_q.single;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a grant/ALU reference model predicts ready and results,
// a separate monitor compares every delivered response.
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic       v0, v1, rdy0, rdy1;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic       rsp_vld, rsp_rdy, rsp_id;
  logic [7:0] out;
  logic       ovf, err, even, single, busy;

  alu_arbiter #(.BITS(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid_0(v0), .i_req_valid_1(v1),
    .o_req_ready_0(rdy0), .o_req_ready_1(rdy1),
    .i_a_0(a0), .i_b_0(b0), .i_a_1(a1), .i_b_1(b1),
    .i_op_0(op0), .i_op_1(op1),
    .o_rsp_valid(rsp_vld), .i_rsp_ready(rsp_rdy), .o_rsp_id(rsp_id),
    .o_out(out), .o_ovf(ovf), .o_err(err), .o_even(even), .o_single(single),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [11:0] res;
    int          acc;
  } exp_t;

  exp_t       sbq[$];
  logic [8:0] dlv[$];
  int checks = 0, failures = 0, cyc = 0;
  int n_acc = 0, n_done = 0;
  int acc_cnt0 = 0, acc_cnt1 = 0, rdyc0 = 0;
  int skip0 = 0, skip1 = 0;
  bit m_ptr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU from the opcode definitions: {out, ovf, err, even, single}.
  function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    logic [7:0]  r;
    logic [15:0] w;
    logic        ov, er;
    r = 8'h00; ov = 1'b0; er = 1'b0;
    case (op)
      2'd0: begin
        r  = a - b;
        ov = (a[7] != b[7]) && (r[7] != a[7]);
      end
      2'd1: r = {5'd0, ($signed(a) < $signed(b)), (a == b), (a < b)};
      2'd2: begin
        er = (b[6:3] != 4'd0);
        if (b[7]) begin
          r = a >> b[2:0];
        end else begin
          w  = 16'(a) << b[2:0];
          r  = w[7:0];
          ov = (w[15:8] != 8'd0);
        end
      end
      default: begin
        er = (b >= 8'd8);
        r  = er ? a : (a ^ (8'd1 << b[2:0]));
      end
    endcase
    return {r, ov, er, ($countones(r) % 2 == 0), ($countones(r) == 1)};
  endfunction

  function automatic logic [7:0] rand_b();
    if ($urandom % 2 == 0) return {1'($urandom), 4'b0000, 3'($urandom)};
    return 8'($urandom);
  endfunction

  // Reference model: predicts grants and pushes expected results at acceptance.
  always @(negedge clk) begin : model
    logic [1:0]  want;
    logic        pick;
    logic [11:0] r;
    if (rst) begin
      chk("reset_outputs", {rdy1, rdy0, rsp_vld, rsp_id, out, ovf, err, even, single, busy}, 0);
      m_ptr = 1'b0;
      n_acc = n_done;
      skip0 = 0;
      skip1 = 0;
    end else begin
      chk("busy", busy, n_acc != n_done);
      want = 2'b00;
      pick = 1'b0;
      if (n_acc == n_done && (v0 || v1)) begin
        pick = (v0 && v1) ? m_ptr : v1;
        want = pick ? 2'b10 : 2'b01;
      end
      chk("ready", {rdy1, rdy0}, want);
      if (rdy0 && v0) acc_cnt0++;
      if (rdy1 && v1) acc_cnt1++;
      if (rdy0) rdyc0++;
      if (want != 2'b00) begin
        if (v0 && v1) begin
          if (pick) skip0++;
          else skip1++;
        end
        chk("fairness_wait", (pick ? skip1 : skip0) <= 1, 1);
        if (pick) skip1 = 0;
        else skip0 = 0;
        r = pick ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
        sbq.push_back('{pick, r, cyc});
        m_ptr = ~pick;
        n_acc++;
      end
    end
  end

  // Monitor: latency, hold stability while stalled, result compare on handshake.
  always @(negedge clk) begin : monitor
    logic        seen;
    logic [12:0] cur, hold;
    #2;
    if (rst) begin
      sbq.delete();
      seen = 1'b0;
    end else if (rsp_vld) begin
      chk("rsp_has_request", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        cur = {rsp_id, out, ovf, err, even, single};
        if (!seen) begin
          chk("latency", cyc - sbq[0].acc, 2);
          hold = cur;
          seen = 1'b1;
        end else begin
          chk("hold_stable", cur, hold);
        end
        if (rsp_rdy) begin
          chk("result", cur, {sbq[0].id, sbq[0].res});
          dlv.push_back({rsp_id, out});
          void'(sbq.pop_front());
          seen = 1'b0;
          n_done++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int k);
    int start, n;
    start = k ? acc_cnt1 : acc_cnt0;
    n = 0;
    while ((k ? acc_cnt1 : acc_cnt0) == start && n < 200) begin
      tick();
      n++;
    end
    chk("accept_in_time", n < 200, 1);
    if (k != 0) v1 = 1'b0;
    else v0 = 1'b0;
  endtask

  task automatic send(input int k, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    if (k != 0) begin
      a1 = a; b1 = b; op1 = op; v1 = 1'b1;
    end else begin
      a0 = a; b0 = b; op0 = op; v0 = 1'b1;
    end
    wait_acc(k);
  endtask

  task automatic wait_dlv(input int n);
    int g;
    g = 0;
    while (dlv.size() < n && g < 100) begin
      tick();
      g++;
    end
    chk("rsp_in_time", dlv.size() >= n, 1);
  endtask

  task automatic wait_rsp();
    int g;
    g = 0;
    while (!rsp_vld && g < 20) begin
      tick();
      g++;
    end
    chk("rsp_valid_seen", rsp_vld, 1);
  endtask

  initial begin : main
    int base, issued, seen0, seen1, guard, dbase;
    // Both valid across reset release; req0 must win on the pointer-0 tie.
    rst = 1'b1; rsp_rdy = 1'b1;
    v0 = 1'b1; a0 = 8'h07; b0 = 8'h40; op0 = 2'b00;
    v1 = 1'b1; a1 = 8'h6F; b1 = 8'h18; op1 = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
    fork
      wait_acc(0);
      wait_acc(1);
    join
    wait_dlv(2);
    chk("tie_first", dlv[0], 9'h0C7);
    chk("tie_second", dlv[1], 9'h157);

    base = rdyc0;
    send(0, 8'hD2, 8'hD5, 2'b00);
    wait_dlv(3);
    chk("single_out", dlv[2], 9'h0FD);
    chk("single_ready_cycles", rdyc0 - base, 1);

    // Backpressure for 5 cycles with a competing request pending.
    rsp_rdy = 1'b0;
    send(1, 8'h35, 8'h03, 2'b10);
    wait_rsp();
    v0 = 1'b1; a0 = 8'h81; b0 = 8'h02; op0 = 2'b11;
    repeat (5) tick();
    chk("bp_busy", busy, 1);
    chk("bp_ready_low", {rdy1, rdy0}, 0);
    chk("bp_valid_held", rsp_vld, 1);
    rsp_rdy = 1'b1;
    wait_acc(0);
    wait_dlv(5);
    chk("bp_shift_out", dlv[3], 9'h1A8);
    chk("bp_bit_out", dlv[4], 9'h085);

    // Reset while EXEC: the op vanishes and the pointer returns to 0.
    send(0, 8'h10, 8'h01, 2'b00);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("flush_no_rsp", dlv.size(), 5);
    fork
      send(0, 8'h55, 8'h05, 2'b01);
      send(1, 8'h0F, 8'h07, 2'b11);
    join
    wait_dlv(7);
    chk("post_rst_first_id", dlv[5][8], 0);
    chk("post_rst_second_id", dlv[6][8], 1);

    // Only req1 active, back to back.
    for (int i = 0; i < 3; i++) send(1, 8'($urandom), rand_b(), 2'($urandom));
    wait_dlv(10);
    for (int i = 7; i < 10; i++) chk("req1_alone_id", dlv[i][8], 1);

    // Random traffic on both ports with random consumer stalls.
    dbase = dlv.size();
    issued = 0; guard = 0;
    seen0 = acc_cnt0; seen1 = acc_cnt1;
    while (dlv.size() - dbase < 1000 && guard < 20000) begin
      tick();
      guard++;
      rsp_rdy = ($urandom % 4) != 0;
      if (acc_cnt0 != seen0) begin
        seen0 = acc_cnt0;
        v0 = 1'b0;
      end
      if (acc_cnt1 != seen1) begin
        seen1 = acc_cnt1;
        v1 = 1'b0;
      end
      if (!v0) begin
        a0 = 8'($urandom); b0 = rand_b(); op0 = 2'($urandom);
        if (issued < 1000 && $urandom % 3 != 0) begin
          v0 = 1'b1;
          issued++;
        end
      end
      if (!v1) begin
        a1 = 8'($urandom); b1 = rand_b(); op1 = 2'($urandom);
        if (issued < 1000 && $urandom % 3 != 0) begin
          v1 = 1'b1;
          issued++;
        end
      end
    end
    chk("random_ops_done", dlv.size() - dbase, 1000);
    rsp_rdy = 1'b1;
    repeat (4) tick();
    chk("scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
